// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared types and reset constants for the serial pattern scan controller.
//   state_t        - handshake/serializer FSM states (IDLE, SHIFT)
//   DEF_PATTERN5   - reset pattern used when PAT_W is 5 (the legacy 10010 detector)
//   DEF_OVERLAP    - reset overlap mode (overlapping matches allowed)
//   DEF_THRESH     - reset irq threshold (0 = irq disabled)
package seq_scan_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [4:0]  DEF_PATTERN5 = 5'b10010;
  localparam logic        DEF_OVERLAP  = 1'b1;
  localparam int unsigned DEF_THRESH   = 0;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: word stream handshake between a producer and seq_scan_ctrl.
//   in_valid - producer has a word
//   in_data  - word, serialized MSB first
//   in_ready - controller can accept a word
// Modports: master (producer side), slave (controller side).
interface seq_scan_ctrl_if #(
  parameter int unsigned WORD_W = 8
) ();

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/seq_match_core.sv
// seq_match_core: serial PAT_W-bit pattern matcher with history that persists
// across words.
//   clk, rst  - clock, synchronous active-high reset
//   bit_vld   - a bit is presented this cycle
//   bit_in    - the presented bit (newest)
//   pattern   - pattern to match; bit PAT_W-1 is the oldest bit
//   overlap   - 1: overlapping matches, 0: restart fill after a match
//   clr_fill  - clear the fill count (history kept)
//   match     - combinational; high when the presented bit completes a match
module seq_match_core #(
  parameter int unsigned PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clr_fill,
  output logic             match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  history_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;

  // Fill saturates at PAT_W, so "next fill >= PAT_W" reduces to equality.
  always_comb begin
    history_nxt = {history[PAT_W-2:0], bit_in};
    fill_nxt    = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
    match       = bit_vld && (fill_nxt == FILL_W'(PAT_W)) && (history_nxt == pattern);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else begin
      if (bit_vld) begin
        history <= history_nxt;
        fill    <= (match && !overlap) ? '0 : fill_nxt;
      end
      if (clr_fill) begin
        fill <= '0;
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts words over a valid/ready handshake, serializes them MSB
// first into seq_match_core, counts matches and raises a sticky threshold irq.
//   clk, rst     - clock, synchronous active-high reset
//   cfg_we       - config write; taken only in IDLE without a same-cycle handshake
//   cfg_pattern  - pattern (bit PAT_W-1 oldest)
//   cfg_overlap  - 1: overlapping matches, 0: restart after a match
//   cfg_thresh   - irq threshold, 0 disables irq
//   in_bus       - word handshake (slave side)
//   irq_clr      - clears irq and match_cnt
//   busy         - serializing a word
//   match_pulse  - one-cycle match indication
//   match_cnt    - saturating match count since last clear
//   irq          - sticky threshold interrupt
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned PAT_W  = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [PAT_W-1:0]     cfg_pattern,
  input  logic                 cfg_overlap,
  input  logic [CNT_W-1:0]     cfg_thresh,
  seq_scan_ctrl_if.slave       in_bus,
  input  logic                 irq_clr,
  output logic                 busy,
  output logic                 match_pulse,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 irq
);

  localparam int unsigned BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [PAT_W-1:0] DEF_PAT = (PAT_W == 5) ? PAT_W'(DEF_PATTERN5) : '0;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [PAT_W-1:0]  pattern_r;
  logic              overlap_r;
  logic [CNT_W-1:0]  thresh_r;

  logic              last_bit;
  logic              hs;
  logic              cfg_take;
  logic              bit_vld;
  logic              match;
  logic [CNT_W-1:0]  cnt_inc;

  // Ready depends only on state and bit_cnt so a new word can be taken in the
  // cycle that feeds the final bit of the current one.
  always_comb begin
    last_bit        = (state == SHIFT) && (bit_cnt == '0);
    in_bus.in_ready = (state == IDLE) || last_bit;
    busy            = (state == SHIFT);
    hs              = in_bus.in_valid && in_bus.in_ready;
    cfg_take        = cfg_we && (state == IDLE) && !hs;
    bit_vld         = (state == SHIFT);
    cnt_inc         = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            sreg    <= in_bus.in_data;
            bit_cnt <= BC_W'(WORD_W - 1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (hs) begin
              sreg    <= in_bus.in_data;
              bit_cnt <= BC_W'(WORD_W - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt - BC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_r <= DEF_PAT;
      overlap_r <= DEF_OVERLAP;
      thresh_r  <= CNT_W'(DEF_THRESH);
    end else if (cfg_take) begin
      pattern_r <= cfg_pattern;
      overlap_r <= cfg_overlap;
      thresh_r  <= cfg_thresh;
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .bit_vld  (bit_vld),
    .bit_in   (sreg[WORD_W-1]),
    .pattern  (pattern_r),
    .overlap  (overlap_r),
    .clr_fill (cfg_take),
    .match    (match)
  );

  // A match coinciding with irq_clr counts as the first match after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_pulse <= 1'b0;
      match_cnt   <= '0;
      irq         <= 1'b0;
    end else begin
      match_pulse <= match;
      if (irq_clr) begin
        match_cnt <= match ? CNT_W'(1) : '0;
        irq       <= match && (thresh_r == CNT_W'(1));
      end else if (match) begin
        match_cnt <= cnt_inc;
        if ((thresh_r != '0) && (cnt_inc == thresh_r)) begin
          irq <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: table-driven directed checks, a throughput sequence and
// randomized traffic against a queue-based reference model.
module tb_seq_scan_ctrl;

  typedef struct {
    bit       rst;
    bit       we;
    bit [4:0] pat;
    bit       ovl;
    bit [7:0] thr;
    bit       clr;
    bit       v;
    bit [7:0] d;
    bit       rdy;
    bit       bsy;
    bit       pul;
    bit [7:0] cnt;
    bit       irq;
  } vec_t;

  localparam bit [4:0] P = 5'b10010;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [4:0] cfg_pattern;
  logic       cfg_overlap;
  logic [7:0] cfg_thresh;
  logic       irq_clr;
  logic       busy;
  logic       match_pulse;
  logic [7:0] match_cnt;
  logic       irq;

  int checks = 0;
  int errors = 0;

  seq_scan_ctrl_if #(.WORD_W(8)) bus ();

  seq_scan_ctrl #(
    .WORD_W (8),
    .PAT_W  (5),
    .CNT_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .in_bus      (bus),
    .irq_clr     (irq_clr),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending bits as a queue, matcher as integer history and
  // a run length of bits since the last restart.
  bit       mq[$];
  int       m_hist = 0;
  int       m_run = 0;
  bit [4:0] m_pat = P;
  bit       m_ovl = 1'b1;
  int       m_thr = 0;
  int       m_cnt = 0;
  bit       m_irq = 1'b0;
  bit       m_pul = 1'b0;

  task automatic model_step(input vec_t v);
    bit idle;
    bit hs;
    bit mt;
    bit b;
    if (v.rst) begin
      mq.delete();
      m_hist = 0; m_run = 0; m_pat = P; m_ovl = 1'b1; m_thr = 0;
      m_cnt = 0; m_irq = 1'b0; m_pul = 1'b0;
      return;
    end
    idle = (mq.size() == 0);
    hs   = v.v && (mq.size() <= 1);
    mt   = 1'b0;
    if (mq.size() > 0) begin
      b = mq.pop_front();
      m_hist = ((m_hist << 1) | int'(b)) & 31;
      m_run++;
      if (m_run >= 5 && m_hist == int'(m_pat)) begin
        mt = 1'b1;
        if (!m_ovl) m_run = 0;
      end
    end
    if (hs) begin
      for (int i = 7; i >= 0; i--) mq.push_back(v.d[i]);
    end
    if (v.we && idle && !hs) begin
      m_pat = v.pat; m_ovl = v.ovl; m_thr = int'(v.thr); m_run = 0;
    end
    if (v.clr) begin
      m_cnt = mt ? 1 : 0;
      m_irq = mt && (m_thr == 1);
    end else if (mt) begin
      if (m_cnt < 255) m_cnt++;
      if (m_thr != 0 && m_cnt == m_thr) m_irq = 1'b1;
    end
    m_pul = mt;
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual %0h required %0h", name, idx, act, exp);
    end
  endtask

  // Drives one cycle of inputs; checks in_ready/busy before the edge and the
  // registered outputs after it. Expectations come from v or from the model.
  task automatic run(input vec_t v, input bit use_model, input bit chk, input int idx);
    bit e_rdy, e_bsy, e_pul, e_irq;
    int e_cnt;
    rst = v.rst; cfg_we = v.we; cfg_pattern = v.pat; cfg_overlap = v.ovl;
    cfg_thresh = v.thr; irq_clr = v.clr; bus.in_valid = v.v; bus.in_data = v.d;
    #2;
    e_rdy = use_model ? (mq.size() <= 1) : v.rdy;
    e_bsy = use_model ? (mq.size() > 0)  : v.bsy;
    if (chk) begin
      cmp("in_ready", idx, 32'(bus.in_ready), 32'(e_rdy));
      cmp("busy", idx, 32'(busy), 32'(e_bsy));
    end
    model_step(v);
    @(posedge clk);
    #1;
    e_pul = use_model ? m_pul : v.pul;
    e_cnt = use_model ? m_cnt : int'(v.cnt);
    e_irq = use_model ? m_irq : v.irq;
    if (chk) begin
      cmp("match_pulse", idx, 32'(match_pulse), 32'(e_pul));
      cmp("match_cnt", idx, 32'(match_cnt), 32'(e_cnt));
      cmp("irq", idx, 32'(irq), 32'(e_irq));
    end
  endtask

  function automatic vec_t row(bit r, bit we, bit [4:0] pat, bit ovl, bit [7:0] thr, bit clr,
                               bit v, bit [7:0] d, bit rdy, bit bsy, bit pul, bit [7:0] cnt, bit ir);
    vec_t x;
    x.rst = r; x.we = we; x.pat = pat; x.ovl = ovl; x.thr = thr; x.clr = clr;
    x.v = v; x.d = d; x.rdy = rdy; x.bsy = bsy; x.pul = pul; x.cnt = cnt; x.irq = ir;
    return x;
  endfunction

  // Plain shift cycle (no handshake, no config, no clear).
  function automatic vec_t sh(bit rdy, bit pul, bit [7:0] cnt, bit ir);
    return row(0, 0, 0, 0, 0, 0, 0, 0, rdy, 1, pul, cnt, ir);
  endfunction

  vec_t tbl[$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   hs_cnt;
    int   n;

    // reset state
    tbl.push_back(row(1,0,0,0,0,0,0,0,        1,0,0,0,0));
    // default config, 0x92 overlapping: matches after bits 5 and 8
    tbl.push_back(row(0,0,0,0,0,0,1,8'h92,    1,0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(sh(0,0,0,0));
    tbl.push_back(sh(0,1,1,0));
    tbl.push_back(sh(0,0,1,0)); tbl.push_back(sh(0,0,1,0));
    tbl.push_back(sh(1,1,2,0));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,2,0));
    // overlap off: single match
    tbl.push_back(row(0,1,P,0,0,1,0,0,        1,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,1,8'h92,    1,0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(sh(0,0,0,0));
    tbl.push_back(sh(0,1,1,0));
    tbl.push_back(sh(0,0,1,0)); tbl.push_back(sh(0,0,1,0));
    tbl.push_back(sh(1,0,1,0));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,1,0));
    // span: 0x09 then 0x00 back-to-back
    tbl.push_back(row(0,1,P,1,0,1,0,0,        1,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,1,8'h09,    1,0,0,0,0));
    for (int k = 0; k < 7; k++) tbl.push_back(sh(0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,1,8'h00,    1,1,0,0,0));
    tbl.push_back(sh(0,1,1,0));
    for (int k = 0; k < 6; k++) tbl.push_back(sh(0,0,1,0));
    tbl.push_back(sh(1,0,1,0));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,1,0));
    // threshold 2: irq on 2nd match, sticky; irq_clr with a match
    tbl.push_back(row(0,1,P,1,2,1,0,0,        1,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,1,8'h92,    1,0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(sh(0,0,0,0));
    tbl.push_back(sh(0,1,1,0));
    tbl.push_back(sh(0,0,1,0)); tbl.push_back(sh(0,0,1,0));
    tbl.push_back(sh(1,1,2,1));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,2,1));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,2,1));
    tbl.push_back(row(0,0,0,0,0,0,1,8'h92,    1,0,0,2,1));
    for (int k = 0; k < 4; k++) tbl.push_back(sh(0,0,2,1));
    tbl.push_back(row(0,0,0,0,0,1,0,0,        0,1,1,1,0));
    tbl.push_back(sh(0,0,1,0)); tbl.push_back(sh(0,0,1,0));
    tbl.push_back(sh(1,1,2,1));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,2,1));
    // cfg_we while busy is ignored
    tbl.push_back(row(0,1,P,1,0,1,0,0,        1,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,1,8'h92,    1,0,0,0,0));
    tbl.push_back(sh(0,0,0,0)); tbl.push_back(sh(0,0,0,0));
    tbl.push_back(row(0,1,5'b11111,0,1,0,0,0, 0,1,0,0,0));
    tbl.push_back(sh(0,0,0,0));
    tbl.push_back(sh(0,1,1,0));
    tbl.push_back(sh(0,0,1,0)); tbl.push_back(sh(0,0,1,0));
    tbl.push_back(sh(1,1,2,0));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,2,0));
    // cfg_we together with a handshake in IDLE is ignored (fill kept)
    tbl.push_back(row(0,1,5'b11111,0,1,0,1,8'h92, 1,0,0,2,0));
    for (int k = 0; k < 4; k++) tbl.push_back(sh(0,0,2,0));
    tbl.push_back(sh(0,1,3,0));
    tbl.push_back(sh(0,0,3,0)); tbl.push_back(sh(0,0,3,0));
    tbl.push_back(sh(1,1,4,0));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,4,0));
    // rst at bit 3, then a clean 0x92
    tbl.push_back(row(0,0,0,0,0,0,1,8'h92,    1,0,0,4,0));
    tbl.push_back(sh(0,0,4,0)); tbl.push_back(sh(0,0,4,0));
    tbl.push_back(row(1,0,0,0,0,0,0,0,        0,1,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,0,0));
    tbl.push_back(row(0,0,0,0,0,0,1,8'h92,    1,0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(sh(0,0,0,0));
    tbl.push_back(sh(0,1,1,0));
    tbl.push_back(sh(0,0,1,0)); tbl.push_back(sh(0,0,1,0));
    tbl.push_back(sh(1,1,2,0));
    tbl.push_back(row(0,0,0,0,0,0,0,0,        1,0,0,2,0));

    v = row(1,0,0,0,0,0,0,0,0,0,0,0,0);
    run(v, 0, 0, 0);
    run(v, 0, 0, 0);

    foreach (tbl[i]) run(tbl[i], 0, 1, i);

    // Sustained input: one acceptance every 8 cycles, then a bounded drain.
    hs_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      v = row(0,0,0,0,0,0,1,8'($urandom),0,0,0,0,0);
      if (mq.size() <= 1) hs_cnt++;
      run(v, 1, 1, 1000 + c);
    end
    cmp("accept_count", 0, 32'(hs_cnt), 32'd3);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      run(row(0,0,0,0,0,0,0,0,0,0,0,0,0), 1, 1, 2000 + n);
      n++;
    end
    cmp("drain_cycles", 0, 32'(n), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      v.rst = ($urandom_range(0, 199) == 0);
      v.we  = ($urandom_range(0, 9) == 0);
      v.pat = ($urandom_range(0, 1) == 1) ? P : 5'($urandom);
      v.ovl = 1'($urandom_range(0, 1));
      v.thr = 8'($urandom_range(0, 6));
      v.clr = ($urandom_range(0, 29) == 0);
      v.v   = 1'($urandom_range(0, 1));
      v.d   = ($urandom_range(0, 3) == 0) ? 8'h92 : 8'($urandom);
      run(v, 1, 1, 10000 + c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that sequences a serial pattern detector from a parallel word stream. It accepts words over a valid/ready handshake and serializes each one MSB-first into a configurable PAT_W-bit pattern matcher. It counts matches and raises a sticky interrupt when a programmable threshold is reached. It sits between a byte-wide producer and software-visible status, and generalizes the team's fixed 10010 detector into a configurable, schedulable resource.

## Interface
- WORD_W, 8, input word width
- PAT_W, 5, pattern length in bits
- CNT_W, 8, match counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- cfg_we  in  1  config write strobe; accepted only in IDLE
- cfg_pattern  in  PAT_W  pattern; bit PAT_W-1 is the oldest bit
- cfg_overlap  in  1  1 = overlapping matches, 0 = restart after a match
- cfg_thresh  in  CNT_W  irq threshold; 0 disables irq
- in_valid  in  1  word valid
- in_data  in  WORD_W  word; serialized MSB first
- in_ready  out  1  controller can accept a word
- irq_clr  in  1  clears irq and match_cnt
- busy  out  1  serializing a word
- match_pulse  out  1  one-cycle match indication
- match_cnt  out  CNT_W  matches since last clear; saturating
- irq  out  1  sticky threshold interrupt

## Operation
- States: IDLE, SHIFT.
  - IDLE: in_ready=1, busy=0. A handshake (in_valid & in_ready) loads the shift register, sets bit_cnt=WORD_W-1 and moves to SHIFT.
  - SHIFT: busy=1. Each cycle, the shift register MSB is fed to the matcher, the register shifts left, and bit_cnt decrements.
  - When bit_cnt==0, in_ready=1. A handshake in that cycle reloads the register and stays in SHIFT (back-to-back, no bubble). Otherwise the FSM returns to IDLE.
- Matcher:
  - Holds a PAT_W-bit history register and a fill count (0..PAT_W, saturating).
  - On each fed bit, next history = {history[PAT_W-2:0], bit} and fill increments.
  - A match occurs when next fill ≥ PAT_W and next history == cfg_pattern.
  - On a match with cfg_overlap=0, fill is set to 0. History is still updated.
  - History persists across words, so patterns can span word boundaries.
- cfg_we:
  - In IDLE with no handshake in the same cycle: latches pattern, overlap and thresh, and clears fill to 0.
  - Otherwise it is ignored, with no partial update.
- Counter: match_cnt increments on each match and saturates at 2^CNT_W-1.
- irq:
  - Sets on the edge where a match makes match_cnt equal cfg_thresh, provided cfg_thresh≠0.
  - Stays set until irq_clr.
- irq_clr:
  - Clears irq and match_cnt.
  - If a match occurs in the same cycle, match_cnt=1 and irq = (cfg_thresh==1).
- Reset values: state IDLE, in_ready=1, busy=0, match_pulse=0, match_cnt=0, irq=0, history=0, fill=0, pattern=5'b10010 (for PAT_W=5; otherwise all zeros), overlap=1, thresh=0.
- rst mid-word: the word in flight is discarded and all state returns to its reset value. Handshakes are ignored while rst is high.

## Timing
- Word accepted at edge T. Bit WORD_W-1-k is fed at edge T+1+k, for k=0..WORD_W-1.
- match_pulse, match_cnt and irq are registered at the same edge as the completing bit, so they are visible in the following cycle.
- Throughput: one word per WORD_W cycles sustained. The first in_ready after a SHIFT ends is at T+WORD_W.
- in_ready and busy are combinational from state and bit_cnt only. They never depend on in_valid.

## Structure
- Package seq_scan_pkg holds:
  - the state enum (IDLE, SHIFT)
  - default pattern, overlap and thresh constants.
- Sub-module seq_match_core holds the history, fill, compare and overlap logic. It has ports: clk, rst, bit_vld, bit_in, pattern, overlap, clr_fill, match.
- The top level holds the handshake FSM, shift register, counter, irq and config registers.

## Test plan
- Default config, feed 0x92 (overlap=1): match_pulse after the 5th and 8th bits, match_cnt=2.
- cfg_overlap=0, feed 0x92: single match after the 5th bit, match_cnt=1.
- Span: feed 0x09 then 0x00 back-to-back: in_ready high in the last SHIFT cycle, no bubble; match after the 1st bit of the 2nd word.
- cfg_thresh=2, feed 0x92: irq rises with the 2nd match and holds. irq_clr pulsed together with a match: match_cnt=1, irq=0.
- cfg_we while busy with pattern 5'b11111: ignored; 0x92 still matches 10010.
- rst asserted at bit 3 of 0x92: no match, all outputs at reset values. A following 0x92 gives match_cnt=2.
